// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the ALU: decodes a MIPS instruction into an ALU op and
// selects the two operands, with EX/MEM and MEM/WB forwarding. The results are
// registered, so the ALU sees them one cycle after the inputs are sampled.
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN. When it is defined,
// o_illegal is registered high for an illegal valid instruction. When it is
// undefined, o_illegal is tied to 0.
module alu_issue_stage #(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_OPERATION = 4,
    parameter int unsigned NB_REG_ADDR  = 5,
    parameter int unsigned NB_INSTR     = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_valid,
    input  logic [NB_INSTR-1:0]     i_instr,
    input  logic [NB_DATA-1:0]      i_rs_data,
    input  logic [NB_DATA-1:0]      i_rt_data,
    input  logic                    i_stall,
    input  logic                    i_flush,
    input  logic                    i_exmem_reg_write,
    input  logic [NB_REG_ADDR-1:0]  i_exmem_rd,
    input  logic [NB_DATA-1:0]      i_exmem_data,
    input  logic                    i_memwb_reg_write,
    input  logic [NB_REG_ADDR-1:0]  i_memwb_rd,
    input  logic [NB_DATA-1:0]      i_memwb_data,
    output logic [NB_DATA-1:0]      o_data_a,
    output logic [NB_DATA-1:0]      o_data_b,
    output logic [NB_OPERATION-1:0] o_alu_op,
    output logic [NB_REG_ADDR-1:0]  o_rd,
    output logic                    o_reg_write,
    output logic                    o_valid,
    output logic                    o_illegal
);

    localparam int unsigned NB_OPCODE = 6;
    localparam int unsigned NB_FUNCT  = 6;
    localparam int unsigned NB_SHAMT  = 5;
    localparam int unsigned NB_IMM    = 16;

    // ALU operation codes
    localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(4'b0000);
    localparam logic [NB_OPERATION-1:0] OP_SUB = NB_OPERATION'(4'b0001);
    localparam logic [NB_OPERATION-1:0] OP_AND = NB_OPERATION'(4'b0010);
    localparam logic [NB_OPERATION-1:0] OP_OR  = NB_OPERATION'(4'b0011);
    localparam logic [NB_OPERATION-1:0] OP_XOR = NB_OPERATION'(4'b0100);
    localparam logic [NB_OPERATION-1:0] OP_NOR = NB_OPERATION'(4'b0101);
    localparam logic [NB_OPERATION-1:0] OP_SRL = NB_OPERATION'(4'b0110);
    localparam logic [NB_OPERATION-1:0] OP_SLL = NB_OPERATION'(4'b0111);
    localparam logic [NB_OPERATION-1:0] OP_SRA = NB_OPERATION'(4'b1000);
    localparam logic [NB_OPERATION-1:0] OP_SLT = NB_OPERATION'(4'b1010);
    localparam logic [NB_OPERATION-1:0] OP_LUI = NB_OPERATION'(4'b1011);
    localparam logic [NB_OPERATION-1:0] OP_ILL = NB_OPERATION'(4'b1111);

    // Major opcodes
    localparam logic [NB_OPCODE-1:0] OPC_RTYPE = 6'h00;
    localparam logic [NB_OPCODE-1:0] OPC_ADDI  = 6'h08;
    localparam logic [NB_OPCODE-1:0] OPC_ADDIU = 6'h09;
    localparam logic [NB_OPCODE-1:0] OPC_SLTI  = 6'h0A;
    localparam logic [NB_OPCODE-1:0] OPC_ANDI  = 6'h0C;
    localparam logic [NB_OPCODE-1:0] OPC_ORI   = 6'h0D;
    localparam logic [NB_OPCODE-1:0] OPC_XORI  = 6'h0E;
    localparam logic [NB_OPCODE-1:0] OPC_LUI   = 6'h0F;
    localparam logic [NB_OPCODE-1:0] OPC_LW    = 6'h23;
    localparam logic [NB_OPCODE-1:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [NB_FUNCT-1:0] FN_SLL  = 6'h00;
    localparam logic [NB_FUNCT-1:0] FN_SRL  = 6'h02;
    localparam logic [NB_FUNCT-1:0] FN_SRA  = 6'h03;
    localparam logic [NB_FUNCT-1:0] FN_SLLV = 6'h04;
    localparam logic [NB_FUNCT-1:0] FN_SRLV = 6'h06;
    localparam logic [NB_FUNCT-1:0] FN_SRAV = 6'h07;
    localparam logic [NB_FUNCT-1:0] FN_ADD  = 6'h20;
    localparam logic [NB_FUNCT-1:0] FN_ADDU = 6'h21;
    localparam logic [NB_FUNCT-1:0] FN_SUB  = 6'h22;
    localparam logic [NB_FUNCT-1:0] FN_SUBU = 6'h23;
    localparam logic [NB_FUNCT-1:0] FN_AND  = 6'h24;
    localparam logic [NB_FUNCT-1:0] FN_OR   = 6'h25;
    localparam logic [NB_FUNCT-1:0] FN_XOR  = 6'h26;
    localparam logic [NB_FUNCT-1:0] FN_NOR  = 6'h27;
    localparam logic [NB_FUNCT-1:0] FN_SLT  = 6'h2A;

    // Instruction fields
    logic [NB_OPCODE-1:0]   w_opcode;
    logic [NB_REG_ADDR-1:0] w_rs_addr;
    logic [NB_REG_ADDR-1:0] w_rt_addr;
    logic [NB_REG_ADDR-1:0] w_rd_addr;
    logic [NB_SHAMT-1:0]    w_shamt;
    logic [NB_FUNCT-1:0]    w_funct;
    logic [NB_IMM-1:0]      w_imm;
    logic [NB_DATA-1:0]     w_imm_sext;
    logic [NB_DATA-1:0]     w_imm_zext;
    logic [NB_DATA-1:0]     w_shamt_zext;
    logic [NB_DATA-1:0]     w_var_shamt;

    // Forwarded register values
    logic [NB_DATA-1:0]     w_rs_fwd;
    logic [NB_DATA-1:0]     w_rt_fwd;

    // Decode results
    logic [NB_DATA-1:0]      w_data_a;
    logic [NB_DATA-1:0]      w_data_b;
    logic [NB_OPERATION-1:0] w_alu_op;
    logic [NB_REG_ADDR-1:0]  w_dest;
    logic                    w_reg_write;
    logic                    w_illegal;

    // Output registers
    logic [NB_DATA-1:0]      r_data_a;
    logic [NB_DATA-1:0]      r_data_b;
    logic [NB_OPERATION-1:0] r_alu_op;
    logic [NB_REG_ADDR-1:0]  r_rd;
    logic                    r_reg_write;
    logic                    r_valid;
    logic                    r_illegal;

    assign w_opcode     = i_instr[31:26];
    assign w_rs_addr    = i_instr[25:21];
    assign w_rt_addr    = i_instr[20:16];
    assign w_rd_addr    = i_instr[15:11];
    assign w_shamt      = i_instr[10:6];
    assign w_funct      = i_instr[5:0];
    assign w_imm        = i_instr[15:0];
    assign w_imm_sext   = {{(NB_DATA-NB_IMM){w_imm[NB_IMM-1]}}, w_imm};
    assign w_imm_zext   = NB_DATA'(w_imm);
    assign w_shamt_zext = NB_DATA'(w_shamt);
    assign w_var_shamt  = NB_DATA'(w_rs_fwd[NB_SHAMT-1:0]);

    // Forwarding mux. EX/MEM has priority over MEM/WB, and $0 is never forwarded.
    always_comb begin
        w_rs_fwd = i_rs_data;
        w_rt_fwd = i_rt_data;
        if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == w_rs_addr)) begin
            w_rs_fwd = i_exmem_data;
        end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == w_rs_addr)) begin
            w_rs_fwd = i_memwb_data;
        end
        if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == w_rt_addr)) begin
            w_rt_fwd = i_exmem_data;
        end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == w_rt_addr)) begin
            w_rt_fwd = i_memwb_data;
        end
    end

    // Instruction decode: ALU op, operand selection and destination register.
    always_comb begin
        w_alu_op    = OP_ADD;
        w_data_a    = w_rs_fwd;
        w_data_b    = w_rt_fwd;
        w_dest      = w_rd_addr;
        w_reg_write = 1'b1;
        w_illegal   = 1'b0;

        case (w_opcode)
            OPC_RTYPE: begin
                w_dest = w_rd_addr;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_alu_op = OP_ADD;
                    FN_SUB, FN_SUBU: w_alu_op = OP_SUB;
                    FN_AND:          w_alu_op = OP_AND;
                    FN_OR:           w_alu_op = OP_OR;
                    FN_XOR:          w_alu_op = OP_XOR;
                    FN_NOR:          w_alu_op = OP_NOR;
                    FN_SLT:          w_alu_op = OP_SLT;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_data_a = w_rt_fwd;
                        w_data_b = w_shamt_zext;
                        w_alu_op = (w_funct == FN_SLL) ? OP_SLL :
                                   (w_funct == FN_SRL) ? OP_SRL : OP_SRA;
                    end
                    FN_SLLV, FN_SRLV, FN_SRAV: begin
                        w_data_a = w_rt_fwd;
                        w_data_b = w_var_shamt;
                        w_alu_op = (w_funct == FN_SLLV) ? OP_SLL :
                                   (w_funct == FN_SRLV) ? OP_SRL : OP_SRA;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW: begin
                w_dest   = w_rt_addr;
                w_alu_op = OP_ADD;
                w_data_b = w_imm_sext;
            end
            OPC_SLTI: begin
                w_dest   = w_rt_addr;
                w_alu_op = OP_SLT;
                w_data_b = w_imm_sext;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                w_dest   = w_rt_addr;
                w_data_b = w_imm_zext;
                w_alu_op = (w_opcode == OPC_ANDI) ? OP_AND :
                           (w_opcode == OPC_ORI)  ? OP_OR  : OP_XOR;
            end
            OPC_LUI: begin
                w_dest   = w_rt_addr;
                w_alu_op = OP_LUI;
                w_data_a = '0;
                w_data_b = w_imm_zext;
            end
            OPC_SW: begin
                w_dest      = w_rt_addr;
                w_alu_op    = OP_ADD;
                w_data_b    = w_imm_sext;
                w_reg_write = 1'b0;
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_alu_op    = OP_ILL;
            w_reg_write = 1'b0;
        end
        if (w_dest == '0) begin
            w_reg_write = 1'b0;
        end
    end

    // Pipeline register. Flush has priority over stall, and stall over load.
    // A load with no valid instruction inserts a bubble.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (i_flush || (!i_stall && !i_valid)) begin
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_alu_op    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_valid     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!i_stall) begin
            r_data_a    <= w_data_a;
            r_data_b    <= w_data_b;
            r_alu_op    <= w_alu_op;
            r_rd        <= w_dest;
            r_reg_write <= w_reg_write;
            r_valid     <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            r_illegal   <= w_illegal;
`else
            r_illegal   <= 1'b0;
`endif
        end
    end

    assign o_data_a    = r_data_a;
    assign o_data_b    = r_data_b;
    assign o_alu_op    = r_alu_op;
    assign o_rd        = r_rd;
    assign o_reg_write = r_reg_write;
    assign o_valid     = r_valid;
    assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage. It applies a table of decode and forwarding
// vectors and then hand-written stall, flush, bubble and reset sequences.
// Each expected result is pushed to a scoreboard queue when its stimulus is
// driven, and popped and compared one cycle later.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic        ill;
        logic        chk_ab;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exd;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwd;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exd;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwd;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        o_vld;
    logic        illegal;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];
    exp_t sb[$];

    alu_issue_stage dut (
        .i_clock          (clk),
        .i_reset          (rst_n),
        .i_valid          (valid),
        .i_instr          (instr),
        .i_rs_data        (rs_data),
        .i_rt_data        (rt_data),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_exmem_reg_write(exw),
        .i_exmem_rd       (exrd),
        .i_exmem_data     (exd),
        .i_memwb_reg_write(mww),
        .i_memwb_rd       (mwrd),
        .i_memwb_data     (mwd),
        .o_data_a         (data_a),
        .o_data_b         (data_b),
        .o_alu_op         (alu_op),
        .o_rd             (rd),
        .o_reg_write      (reg_write),
        .o_valid          (o_vld),
        .o_illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rdf, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rdf, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op, input logic [4:0] rdv,
                                    input logic rw, input logic vld, input logic ill,
                                    input logic chk);
        exp_t e;
        e.a = a; e.b = b; e.op = op; e.rd = rdv; e.rw = rw;
        e.valid = vld; e.ill = ill; e.chk_ab = chk;
        return e;
    endfunction

    task automatic add(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic xw, input logic [4:0] xrd, input logic [31:0] xd,
                       input logic ww, input logic [4:0] wrd, input logic [31:0] wd,
                       input exp_t e);
        vec_t v;
        v.instr = ins; v.rs_d = rsd; v.rt_d = rtd;
        v.exw = xw; v.exrd = xrd; v.exd = xd;
        v.mww = ww; v.mwrd = wrd; v.mwd = wd;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s actual=empty_queue expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".valid"}, 32'(o_vld), 32'(e.valid));
        cmp({tag, ".rw"}, 32'(reg_write), 32'(e.rw));
        cmp({tag, ".ill"}, 32'(illegal), 32'(e.ill));
        if (e.valid) cmp({tag, ".op"}, 32'(alu_op), 32'(e.op));
        if (e.chk_ab || !e.valid) begin
            cmp({tag, ".a"}, data_a, e.a);
            cmp({tag, ".b"}, data_b, e.b);
        end
        if (e.valid && e.chk_ab) cmp({tag, ".rd"}, 32'(rd), 32'(e.rd));
    endtask

    task automatic drive(input vec_t v);
        instr   = v.instr;  rs_data = v.rs_d; rt_data = v.rt_d;
        exw     = v.exw;    exrd    = v.exrd; exd     = v.exd;
        mww     = v.mww;    mwrd    = v.mwrd; mwd     = v.mwd;
    endtask

    // Drive on the falling edge, capture on the rising edge, check 1 time unit later.
    task automatic step(input vec_t v, input logic vld, input logic stl, input logic fl,
                        input exp_t e, input string tag);
        @(negedge clk);
        drive(v);
        valid = vld; stall = stl; flush = fl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    initial begin
        exp_t bub;
        exp_t ori_e;
        vec_t v;

        bub = mk_exp(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // ADDI $2,$1,-4
        add(i_type(6'h08, 5'd1, 5'd2, 16'hFFFC), 32'd10, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd10, 32'hFFFFFFFC, 4'h0, 5'd2, 1, 1, 0, 1));
        // SRA $3,$4,5
        add(r_type(5'd0, 5'd4, 5'd3, 5'd5, 6'h03), 32'd0, 32'h80000000, 0, 0, 0, 0, 0, 0,
            mk_exp(32'h80000000, 32'd5, 4'h8, 5'd3, 1, 1, 0, 1));
        // ADD $5,$1,$1: EX/MEM wins over MEM/WB
        add(r_type(5'd1, 5'd1, 5'd5, 5'd0, 6'h20), 32'd100, 32'd100, 1, 5'd1, 32'd7, 1, 5'd1, 32'd9,
            mk_exp(32'd7, 32'd7, 4'h0, 5'd5, 1, 1, 0, 1));
        // The same with EX/MEM rd = 0, so MEM/WB forwards
        add(r_type(5'd1, 5'd1, 5'd5, 5'd0, 6'h20), 32'd100, 32'd100, 1, 5'd0, 32'd7, 1, 5'd1, 32'd9,
            mk_exp(32'd9, 32'd9, 4'h0, 5'd5, 1, 1, 0, 1));
        // SUB $6,$7,$8
        add(r_type(5'd7, 5'd8, 5'd6, 5'd0, 6'h22), 32'd20, 32'd3, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd20, 32'd3, 4'h1, 5'd6, 1, 1, 0, 1));
        // ANDI zero-extends the immediate
        add(i_type(6'h0C, 5'd10, 5'd9, 16'h8001), 32'hFFFF0000, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'hFFFF0000, 32'h00008001, 4'h2, 5'd9, 1, 1, 0, 1));
        // LUI forces A to 0
        add(i_type(6'h0F, 5'd0, 5'd11, 16'h1234), 32'h55, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd0, 32'h1234, 4'hB, 5'd11, 1, 1, 0, 1));
        // SW does not write a register
        add(i_type(6'h2B, 5'd13, 5'd12, 16'hFFF8), 32'h1000, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'h1000, 32'hFFFFFFF8, 4'h0, 5'd12, 0, 1, 0, 1));
        // Destination $0 suppresses the write
        add(r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd4, 32'd5, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd4, 32'd5, 4'h0, 5'd0, 0, 1, 0, 1));
        // SLLV: shift amount is rs[4:0]
        add(r_type(5'd16, 5'd15, 5'd14, 5'd0, 6'h04), 32'h123, 32'd1, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd1, 32'd3, 4'h7, 5'd14, 1, 1, 0, 1));
        // SLT
        add(r_type(5'd18, 5'd19, 5'd17, 5'd0, 6'h2A), 32'd5, 32'd6, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd5, 32'd6, 4'hA, 5'd17, 1, 1, 0, 1));
        // NOR
        add(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'hAAAA, 32'h5555, 0, 0, 0, 0, 0, 0,
            mk_exp(32'hAAAA, 32'h5555, 4'h5, 5'd3, 1, 1, 0, 1));
        // SLTI sign-extends the immediate
        add(i_type(6'h0A, 5'd3, 5'd4, 16'h8000), 32'd1, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd1, 32'hFFFF8000, 4'hA, 5'd4, 1, 1, 0, 1));
        // XORI zero-extends the immediate
        add(i_type(6'h0E, 5'd3, 5'd4, 16'h8000), 32'd1, 32'd0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd1, 32'h00008000, 4'h4, 5'd4, 1, 1, 0, 1));
        // SRL with shamt 31
        add(r_type(5'd0, 5'd6, 5'd7, 5'd31, 6'h02), 32'd0, 32'hF0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'hF0, 32'd31, 4'h6, 5'd7, 1, 1, 0, 1));
        // Register 0 is never forwarded
        add(r_type(5'd0, 5'd0, 5'd5, 5'd0, 6'h21), 32'd3, 32'd3, 1, 5'd0, 32'd77, 1, 5'd0, 32'd88,
            mk_exp(32'd3, 32'd3, 4'h0, 5'd5, 1, 1, 0, 1));
        // OR: rs from EX/MEM, rt from MEM/WB
        add(r_type(5'd1, 5'd2, 5'd8, 5'd0, 6'h25), 32'd1, 32'd2, 1, 5'd1, 32'hAA, 1, 5'd2, 32'hBB,
            mk_exp(32'hAA, 32'hBB, 4'h3, 5'd8, 1, 1, 0, 1));
        // XOR: EX/MEM not writing, so MEM/WB forwards
        add(r_type(5'd1, 5'd1, 5'd8, 5'd0, 6'h26), 32'd1, 32'd1, 0, 5'd1, 32'h11, 1, 5'd1, 32'h22,
            mk_exp(32'h22, 32'h22, 4'h4, 5'd8, 1, 1, 0, 1));
        // LW with rs forwarded from MEM/WB
        add(i_type(6'h23, 5'd5, 5'd6, 16'h0004), 32'd200, 32'd0, 0, 0, 0, 1, 5'd5, 32'd300,
            mk_exp(32'd300, 32'd4, 4'h0, 5'd6, 1, 1, 0, 1));
        // SRAV
        add(r_type(5'd9, 5'd10, 5'd11, 5'd0, 6'h07), 32'h24, 32'hFFFFFFF0, 0, 0, 0, 0, 0, 0,
            mk_exp(32'hFFFFFFF0, 32'd4, 4'h8, 5'd11, 1, 1, 0, 1));
        // Illegal opcode 0x3F
        add(i_type(6'h3F, 5'd1, 5'd2, 16'h0), 32'd1, 32'd2, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd0, 32'd0, 4'hF, 5'd0, 0, 1, TRAP, 0));
        // Illegal R-type funct 0x01
        add(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h01), 32'd1, 32'd2, 0, 0, 0, 0, 0, 0,
            mk_exp(32'd0, 32'd0, 4'hF, 5'd0, 0, 1, TRAP, 0));

        rst_n = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;
        exw = 1'b0; exrd = '0; exd = '0; mww = 1'b0; mwrd = '0; mwd = '0;
        #12;
        cmp("reset.valid", 32'(o_vld), 32'd0);
        cmp("reset.op", 32'(alu_op), 32'd0);
        cmp("reset.a", data_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], 1'b1, 1'b0, 1'b0, vecs[i].e, $sformatf("vec%0d", i));
        end

        // ORI, two stall cycles with different inputs, then stall and flush together
        v = vecs[0];
        v.instr = i_type(6'h0D, 5'd21, 5'd20, 16'h00F0);
        v.rs_d  = 32'h0F00;
        ori_e = mk_exp(32'h0F00, 32'h00F0, 4'h3, 5'd20, 1, 1, 0, 1);
        step(v, 1'b1, 1'b0, 1'b0, ori_e, "ori");
        v.instr = r_type(5'd7, 5'd8, 5'd6, 5'd0, 6'h22);
        v.rs_d  = 32'd999;
        step(v, 1'b1, 1'b1, 1'b0, ori_e, "stall1");
        step(v, 1'b0, 1'b1, 1'b0, ori_e, "stall2");
        step(v, 1'b1, 1'b1, 1'b1, bub, "stall_flush");

        // A load with i_valid = 0 is a bubble
        step(vecs[0], 1'b1, 1'b0, 1'b0, vecs[0].e, "pre_bubble");
        step(vecs[0], 1'b0, 1'b0, 1'b0, bub, "bubble");

        // Illegal instruction held by stall, then cleared by flush
        step(vecs[vecs.size()-2], 1'b1, 1'b0, 1'b0, vecs[vecs.size()-2].e, "ill");
        step(vecs[1], 1'b1, 1'b1, 1'b0, vecs[vecs.size()-2].e, "ill_stall");
        step(vecs[1], 1'b1, 1'b0, 1'b1, bub, "ill_flush");

        // Reset asserted mid-cycle clears the outputs without a clock edge
        step(vecs[1], 1'b1, 1'b0, 1'b0, vecs[1].e, "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset.valid", 32'(o_vld), 32'd0);
        cmp("async_reset.a", data_a, 32'd0);
        cmp("async_reset.b", data_b, 32'd0);
        cmp("async_reset.op", 32'(alu_op), 32'd0);
        cmp("async_reset.rd", 32'(rd), 32'd0);
        cmp("async_reset.rw", 32'(reg_write), 32'd0);
        cmp("async_reset.ill", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(vecs[0], 1'b1, 1'b0, 1'b0, vecs[0].e, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
